// File: rtl/t5_barb_pkg.sv
// t5_barb_pkg: shared types and constants for the two-master bus arbiter.
package t5_barb_pkg;

  // Default number of unanswered granted cycles before the arbiter gives up.
  localparam int unsigned TMO_DEFAULT = 15;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_IGNT = 2'd1,
    ST_DGNT = 2'd2
  } state_e;

  // Which master was served most recently.
  typedef enum logic {
    M_INSN = 1'b0,
    M_DATA = 1'b1
  } master_e;

  // Choose the next grant from IDLE; under contention, favour the master not served last.
  function automatic state_e arb_pick(input logic istb, input logic dstb, input master_e last);
    state_e s;
    s = ST_IDLE;
    if (istb && dstb) begin
      s = (last == M_INSN) ? ST_DGNT : ST_IGNT;
    end else if (dstb) begin
      s = ST_DGNT;
    end else if (istb) begin
      s = ST_IGNT;
    end else begin
      s = ST_IDLE;
    end
    return s;
  endfunction

endpackage

// File: rtl/t5_barb_if.sv
// t5_barb_if: one Wishbone-style bus leg (request, write data, read data, ack).
interface t5_barb_if;
  logic [29:0] adr;
  logic [31:0] dto;
  logic [31:0] dti;
  logic [3:0]  sel;
  logic        wre;
  logic        stb;
  logic        ack;

  modport master (output adr, dto, sel, wre, stb, input  dti, ack);
  modport slave  (input  adr, dto, sel, wre, stb, output dti, ack);
endinterface

// File: rtl/t5_barb_tmo.sv
// t5_barb_tmo: per-grant wait counter with a compare against the timeout limit.
module t5_barb_tmo
  import t5_barb_pkg::*;
#(
  parameter int unsigned TMO = TMO_DEFAULT
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_hit
);

  localparam logic [7:0] TMO_W = 8'(TMO);

  logic [7:0] r_cnt;

  // Count granted cycles that went unanswered; cleared whenever no grant is live.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_cnt <= 8'd0;
    end else if (i_clr) begin
      r_cnt <= 8'd0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + 8'd1;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_hit = (r_cnt == TMO_W);

endmodule

// File: rtl/t5_barb.sv
// t5_barb: arbitrates the core's instruction and data buses onto one memory slave.
module t5_barb
  import t5_barb_pkg::*;
#(
  parameter int unsigned TMO = TMO_DEFAULT
) (
  input  logic      sys_clk,
  input  logic      sys_rst,
  t5_barb_if.slave  iwb,
  t5_barb_if.slave  dwb,
  t5_barb_if.master mem,
  output logic      bus_err
);

  state_e      r_state;
  state_e      w_nxt;
  master_e     r_last;
  logic        w_granted;
  logic        w_gnt_stb;
  logic        w_abort;
  logic        w_ack_ok;
  logic        w_tmo;
  logic        w_done;
  logic        w_leave;
  logic        w_hit;
  logic [31:0] w_rdat;
  logic [29:0] r_mem_adr;
  logic [31:0] r_mem_dto;
  logic [3:0]  r_mem_sel;
  logic        r_mem_wre;
  logic        r_mem_stb;

  // Decode the live grant and how the current granted cycle ends (ack, timeout or abort).
  always_comb begin
    w_gnt_stb = 1'b0;
    case (r_state)
      ST_IGNT: w_gnt_stb = iwb.stb;
      ST_DGNT: w_gnt_stb = dwb.stb;
      default: w_gnt_stb = 1'b0;
    endcase
    w_granted = (r_state != ST_IDLE);
    w_abort   = w_granted & ~w_gnt_stb;
    w_ack_ok  = w_granted & w_gnt_stb & mem.ack;
    // A real slave ack in the limit cycle wins over the timeout.
    w_tmo     = w_granted & w_gnt_stb & ~mem.ack & w_hit;
    w_done    = w_ack_ok | w_tmo;
  end

  // Next-state logic: arbitrate in IDLE, hold a grant for exactly one transfer.
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      ST_IDLE: w_nxt = arb_pick(iwb.stb, dwb.stb, r_last);
      ST_IGNT, ST_DGNT: begin
        if (w_abort || w_done) begin
          w_nxt = ST_IDLE;
        end else begin
          w_nxt = r_state;
        end
      end
      default: w_nxt = ST_IDLE;
    endcase
  end

  assign w_leave = w_granted & (w_nxt == ST_IDLE);

  // FSM state register.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nxt;
    end
  end

  // Remember who was served on every grant exit so contention alternates.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_last <= M_INSN;
    end else if (w_leave) begin
      r_last <= (r_state == ST_DGNT) ? M_DATA : M_INSN;
    end else begin
      r_last <= r_last;
    end
  end

  // Register the slave-side request from the master that owns the next cycle.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_mem_adr <= 30'd0;
      r_mem_dto <= 32'd0;
      r_mem_sel <= 4'd0;
      r_mem_wre <= 1'b0;
      r_mem_stb <= 1'b0;
    end else begin
      case (w_nxt)
        ST_IGNT: begin
          // Instruction fetches are read-only.
          r_mem_adr <= iwb.adr;
          r_mem_dto <= 32'd0;
          r_mem_sel <= iwb.sel;
          r_mem_wre <= 1'b0;
          r_mem_stb <= iwb.stb;
        end
        ST_DGNT: begin
          r_mem_adr <= dwb.adr;
          r_mem_dto <= dwb.dto;
          r_mem_sel <= dwb.sel;
          r_mem_wre <= dwb.wre;
          r_mem_stb <= dwb.stb;
        end
        default: begin
          r_mem_adr <= 30'd0;
          r_mem_dto <= 32'd0;
          r_mem_sel <= 4'd0;
          r_mem_wre <= 1'b0;
          r_mem_stb <= 1'b0;
        end
      endcase
    end
  end

  t5_barb_tmo #(
    .TMO (TMO)
  ) u_tmo (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .i_clr   (~w_granted | w_leave),
    .i_inc   (w_granted & ~mem.ack & ~w_leave),
    .o_hit   (w_hit)
  );

  assign mem.adr = r_mem_adr;
  assign mem.dto = r_mem_dto;
  assign mem.sel = r_mem_sel;
  assign mem.wre = r_mem_wre;
  assign mem.stb = r_mem_stb;

  // Timeout returns zero read data alongside the forced ack.
  assign w_rdat  = w_tmo ? 32'd0 : mem.dti;
  assign iwb.dti = w_rdat;
  assign dwb.dti = w_rdat;
  assign iwb.ack = (r_state == ST_IGNT) & w_done;
  assign dwb.ack = (r_state == ST_DGNT) & w_done;
  assign bus_err = w_tmo;

endmodule

// File: tb/tb_t5_barb.sv
// tb_t5_barb: directed self-checking bench for the t5_barb bus arbiter (TMO=3).
module tb_t5_barb;

  logic sys_clk;
  logic sys_rst;
  logic bus_err;
  int   checks;
  int   failures;

  t5_barb_if iwb ();
  t5_barb_if dwb ();
  t5_barb_if mem ();

  t5_barb #(
    .TMO (3)
  ) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .iwb     (iwb),
    .dwb     (dwb),
    .mem     (mem),
    .bus_err (bus_err)
  );

  // 100 MHz free-running clock.
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #2;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    sys_rst  = 1'b0;
    iwb.adr = 30'd0; iwb.dto = 32'd0; iwb.sel = 4'd0; iwb.wre = 1'b0; iwb.stb = 1'b0;
    dwb.adr = 30'd0; dwb.dto = 32'd0; dwb.sel = 4'd0; dwb.wre = 1'b0; dwb.stb = 1'b0;
    mem.dti = 32'd0; mem.ack = 1'b0;
    #1;
    chk1("rst_mem_stb", mem.stb, 1'b0);
    chk1("rst_mem_wre", mem.wre, 1'b0);
    chkw("rst_mem_sel", 32'(mem.sel), 32'h0000_0000);
    chk1("rst_iack", iwb.ack, 1'b0);
    chk1("rst_dack", dwb.ack, 1'b0);
    chk1("rst_berr", bus_err, 1'b0);
    tick();
    tick();
    sys_rst = 1'b1;
    tick();

    // Instruction fetch at 0x100 with two wait cycles.
    iwb.adr = 30'h0000_0040; iwb.sel = 4'hF; iwb.stb = 1'b1;
    #1 chk1("fetch_arb_no_stb", mem.stb, 1'b0);
    tick(); #1;
    chk1("fetch_g1_stb", mem.stb, 1'b1);
    chkw("fetch_g1_adr", 32'(mem.adr), 32'h0000_0040);
    chk1("fetch_g1_wre", mem.wre, 1'b0);
    chk1("fetch_g1_iack", iwb.ack, 1'b0);
    tick(); #1;
    chk1("fetch_g2_iack", iwb.ack, 1'b0);
    tick();
    mem.ack = 1'b1; mem.dti = 32'h0000_0013;
    #1;
    chk1("fetch_c4_iack", iwb.ack, 1'b1);
    chkw("fetch_c4_idat", iwb.dti, 32'h0000_0013);
    chk1("fetch_c4_dack", dwb.ack, 1'b0);
    chk1("fetch_c4_berr", bus_err, 1'b0);
    tick();
    mem.ack = 1'b0; iwb.stb = 1'b0;
    #1;
    chk1("fetch_done_stb", mem.stb, 1'b0);
    chk1("fetch_done_iack", iwb.ack, 1'b0);
    // A stray slave ack while idle must not reach either master.
    mem.ack = 1'b1;
    #1;
    chk1("idle_ack_i", iwb.ack, 1'b0);
    chk1("idle_ack_d", dwb.ack, 1'b0);
    tick();
    mem.ack = 1'b0;

    // Fresh reset, then simultaneous requests: data first, then instruction.
    sys_rst = 1'b0;
    #1;
    tick();
    sys_rst = 1'b1;
    iwb.adr = 30'h0000_0041; iwb.dto = 32'hFFFF_FFFF; iwb.wre = 1'b1; iwb.stb = 1'b1;
    dwb.adr = 30'h0000_0080; dwb.dto = 32'hDEAD_BEEF; dwb.sel = 4'hF; dwb.wre = 1'b1; dwb.stb = 1'b1;
    #1 chk1("both_arb_no_stb", mem.stb, 1'b0);
    tick(); #1;
    chk1("both_d_stb", mem.stb, 1'b1);
    chkw("both_d_adr", 32'(mem.adr), 32'h0000_0080);
    chk1("both_d_wre", mem.wre, 1'b1);
    chkw("both_d_dto", mem.dto, 32'hDEAD_BEEF);
    chkw("both_d_sel", 32'(mem.sel), 32'h0000_000F);
    mem.ack = 1'b1;
    #1;
    chk1("both_d_dack", dwb.ack, 1'b1);
    chk1("both_d_iack", iwb.ack, 1'b0);
    tick();
    mem.ack = 1'b0; dwb.stb = 1'b0; dwb.wre = 1'b0;
    #1 chk1("both_idle_gap", mem.stb, 1'b0);
    tick(); #1;
    chk1("both_i_stb", mem.stb, 1'b1);
    chkw("both_i_adr", 32'(mem.adr), 32'h0000_0041);
    chk1("both_i_wre_forced", mem.wre, 1'b0);
    chkw("both_i_dto_zero", mem.dto, 32'h0000_0000);
    mem.ack = 1'b1; mem.dti = 32'h0000_0093;
    #1;
    chk1("both_i_iack", iwb.ack, 1'b1);
    chk1("both_i_dack", dwb.ack, 1'b0);
    tick();
    mem.ack = 1'b0; iwb.stb = 1'b0; iwb.wre = 1'b0;

    // Both request continuously: grants alternate D, I, D, I.
    iwb.stb = 1'b1; dwb.stb = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1 chk1("rr_arb_no_stb", mem.stb, 1'b0);
      tick(); #1;
      chkw("rr_adr", 32'(mem.adr), (k % 2 == 0) ? 32'h0000_0080 : 32'h0000_0041);
      mem.ack = 1'b1;
      #1;
      chk1("rr_dack", dwb.ack, (k % 2 == 0));
      chk1("rr_iack", iwb.ack, (k % 2 == 1));
      tick();
      mem.ack = 1'b0;
    end
    iwb.stb = 1'b0; dwb.stb = 1'b0;

    // Data master drops stb before any ack: abort, and the next contention goes to instruction.
    dwb.stb = 1'b1;
    tick(); #1;
    chk1("abort_g1_stb", mem.stb, 1'b1);
    tick();
    dwb.stb = 1'b0; mem.ack = 1'b1;
    #1;
    chk1("abort_no_dack", dwb.ack, 1'b0);
    chk1("abort_no_berr", bus_err, 1'b0);
    tick();
    mem.ack = 1'b0;
    #1 chk1("abort_idle_stb", mem.stb, 1'b0);
    iwb.stb = 1'b1; dwb.stb = 1'b1;
    tick(); #1;
    chkw("abort_next_is_i", 32'(mem.adr), 32'h0000_0041);
    mem.ack = 1'b1;
    #1 chk1("abort_next_iack", iwb.ack, 1'b1);
    tick();
    mem.ack = 1'b0; iwb.stb = 1'b0; dwb.stb = 1'b0;

    // Slave never answers: forced ack with zero data and bus_err on the 4th granted cycle.
    dwb.adr = 30'h0000_0090; dwb.stb = 1'b1; mem.dti = 32'hCAFE_F00D;
    tick();
    for (int g = 1; g < 4; g++) begin
      #1;
      chk1("tmo_wait_dack", dwb.ack, 1'b0);
      chk1("tmo_wait_berr", bus_err, 1'b0);
      tick();
    end
    #1;
    chk1("tmo_dack", dwb.ack, 1'b1);
    chk1("tmo_berr", bus_err, 1'b1);
    chkw("tmo_ddat_zero", dwb.dti, 32'h0000_0000);
    tick();
    dwb.stb = 1'b0;
    #1;
    chk1("tmo_after_berr", bus_err, 1'b0);
    chk1("tmo_after_dack", dwb.ack, 1'b0);
    chk1("tmo_after_stb", mem.stb, 1'b0);

    // Slave answers exactly in the limit cycle: normal ack, no bus_err.
    dwb.stb = 1'b1;
    tick();
    tick();
    tick();
    tick();
    mem.ack = 1'b1; mem.dti = 32'h1234_5678;
    #1;
    chk1("edge_dack", dwb.ack, 1'b1);
    chkw("edge_ddat", dwb.dti, 32'h1234_5678);
    chk1("edge_berr", bus_err, 1'b0);
    tick();
    mem.ack = 1'b0; dwb.stb = 1'b0;

    // Reset in the middle of a data wait; data was served last before it.
    dwb.stb = 1'b1;
    tick();
    tick();
    sys_rst = 1'b0;
    #1;
    chk1("mid_rst_stb", mem.stb, 1'b0);
    chk1("mid_rst_dack", dwb.ack, 1'b0);
    tick();
    sys_rst = 1'b1; mem.ack = 1'b1; iwb.stb = 1'b1; dwb.stb = 1'b1;
    #1;
    chk1("post_rst_no_dack", dwb.ack, 1'b0);
    chk1("post_rst_no_iack", iwb.ack, 1'b0);
    mem.ack = 1'b0;
    tick(); #1;
    chk1("post_rst_stb", mem.stb, 1'b1);
    chkw("post_rst_data_first", 32'(mem.adr), 32'h0000_0090);
    mem.ack = 1'b1;
    #1 chk1("post_rst_dack", dwb.ack, 1'b1);
    tick();
    mem.ack = 1'b0; iwb.stb = 1'b0; dwb.stb = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/t5_barb.md
T5_BARB -- requirements
Module: t5_barb

Interface
REQ-001 SHALL have parameter TMO, default 15: bus-timeout limit in cycles (1..255).
REQ-002 SHALL have one clock; reset is asynchronous and active-low.
REQ-003 sys_clk  in  1  system clock; all state changes on its rising edge.
REQ-004 sys_rst  in  1  asynchronous active-low reset.
REQ-005 iwb_adr in 30 [31:2]; iwb_stb in 1; iwb_wre in 1; iwb_sel in 4: instruction master request.
REQ-006 iwb_dat out 32; iwb_ack out 1: instruction read data and acknowledge.
REQ-007 dwb_adr in 30 [31:2]; dwb_dto in 32; dwb_sel in 4; dwb_wre in 1; dwb_stb in 1: data master request.
REQ-008 dwb_dti out 32; dwb_ack out 1: data read data and acknowledge.
REQ-009 mem_adr out 30 [31:2]; mem_dto out 32; mem_sel out 4; mem_wre out 1; mem_stb out 1: shared slave port.
REQ-010 mem_dti in 32; mem_ack in 1: shared slave read data and acknowledge.
REQ-011 bus_err out 1: one-cycle pulse on timeout.

Function
REQ-012 SHALL run a 3-state FSM: IDLE, IGNT (instruction granted), DGNT (data granted).
REQ-013 IDLE: only dwb_stb -> DGNT; only iwb_stb -> IGNT; both -> the master not served last; neither -> stay.
REQ-014 The last-served flag SHALL update on every exit from IGNT/DGNT; its reset value is "instruction", so the first contention goes to data.
REQ-015 Grant SHALL be registered: mem_stb rises the cycle after the grant state is entered; there is no combinational path from *_stb to mem_stb.
REQ-016 In IGNT/DGNT, mem_adr, mem_sel, mem_wre and mem_dto SHALL mux from the granted master; mem_stb = granted master's stb.
REQ-017 In IGNT, mem_wre SHALL be forced 0; mem_dto SHALL be 0.
REQ-018 In IDLE, mem_stb, mem_wre and mem_sel SHALL be 0.
REQ-019 mem_ack SHALL route combinationally to the granted master's ack only; the other ack is 0.
REQ-020 mem_dti SHALL route to both iwb_dat and dwb_dti.
REQ-021 One transfer per grant: the cycle with mem_ack=1 SHALL return the FSM to IDLE.
REQ-022 Granted master deasserting stb before ack SHALL abort: next state IDLE, no ack issued, last-served updated.
REQ-023 mem_ack while in IDLE SHALL be ignored.
REQ-024 An 8-bit wait counter SHALL clear on grant entry and increment each granted cycle without mem_ack.
REQ-025 Timeout: when the counter equals TMO, the arbiter SHALL assert the granted master's ack for one cycle with zero read data, pulse bus_err, and return to IDLE.
REQ-026 mem_ack arriving in the timeout cycle SHALL take precedence: normal ack, no bus_err.
REQ-027 Minimum transfer: 1 cycle arbitrate, then 1 cycle with a zero-wait slave; back-to-back transfers from one master SHALL see one IDLE cycle between them.

Reset
REQ-028 On sys_rst low: FSM=IDLE, counter=0, last-served=instruction, bus_err=0, mem_stb=0, iwb_ack=0, dwb_ack=0, immediately and asynchronously.
REQ-029 Reset mid-transfer SHALL drop mem_stb the same cycle; the outstanding transfer is discarded, with no ack after release.

Structure
REQ-030 FSM state encodings and default TMO SHALL live in the shared t5 package used by the core.
REQ-031 The block SHALL be flat apart from one sub-module, t5_barb_tmo (wait counter plus compare), instantiated once.
REQ-032 t5_barb SHALL sit between the core's iwb/dwb ports and a single memory slave, and SHALL require no change to the core.

Verification
REQ-033 iwb_stb=1, adr=0x0000_0100>>2; slave acks with 0x00000013 after 2 waits -> iwb_ack on cycle 4, iwb_dat=0x00000013, dwb_ack=0.
REQ-034 iwb_stb and dwb_stb rise together after reset; dwb write 0xDEADBEEF, sel=4'hF -> data served first, mem_wre=1; instruction served next, with one IDLE cycle between.
REQ-035 Both masters request continuously -> grants alternate D,I,D,I over 4 transfers; neither master starves.
REQ-036 TMO=3, slave never acks -> dwb_ack and bus_err pulse on the 4th granted cycle, dwb_dti=0, FSM back to IDLE.
REQ-037 Slave acks exactly on the timeout cycle -> normal ack with slave data, bus_err stays 0.
REQ-038 Assert sys_rst low mid-wait in DGNT -> mem_stb=0 the same cycle; after release, no spurious ack and the next contention goes to data.
